// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU trigger, cpu_memory DMA read port and PPU OAM write port bundle
interface oam_dma_if;
    // CPU side: write strobe, address and data of the current CPU cycle
    logic        cpu_w;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;

    // cpu_memory dedicated DMA read port (combinational read data)
    logic [15:0] mem_address;
    logic        mem_r;
    logic [7:0]  mem_data;

    // PPU OAM write port
    logic        oam_w;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;

    // Status toward the CPU core and the rest of the system
    logic        cpu_halt;
    logic        busy;
    logic        done;

    // The DMA engine side
    modport master (
        input  cpu_w,
        input  cpu_address,
        input  cpu_data,
        input  mem_data,
        output mem_address,
        output mem_r,
        output oam_w,
        output oam_address,
        output oam_data,
        output cpu_halt,
        output busy,
        output done
    );

    // The system side: CPU, cpu_memory and OAM
    modport slave (
        output cpu_w,
        output cpu_address,
        output cpu_data,
        output mem_data,
        input  mem_address,
        input  mem_r,
        input  oam_w,
        input  oam_address,
        input  oam_data,
        input  cpu_halt,
        input  busy,
        input  done
    );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - NES $4014 sprite DMA engine copying one CPU page into PPU OAM
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256
) (
    input  logic     CLK,
    input  logic     Reset,
    oam_dma_if.master bus
);

    // Index of the final byte; XFER_LEN is a power of two no larger than 256
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state, state_next;
    logic [7:0] idx, idx_next;
    logic [7:0] page, page_next;
    logic [7:0] buffer, buffer_next;
    logic       parity;

    logic       trigger;

    // A CPU write to the DMA register; only honoured while idle
    assign trigger = bus.cpu_w && (bus.cpu_address == DMA_REG_ADDR);

    // Even/odd CPU cycle tracker, free-running outside reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    // State, byte index, source page and the byte in flight
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= 8'd0;
            page   <= 8'd0;
            buffer <= 8'd0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            page   <= page_next;
            buffer <= buffer_next;
        end
    end

    // Next-state logic: halt, optional odd-cycle alignment, then READ/WRITE pairs
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        page_next   = page;
        buffer_next = buffer;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    page_next  = bus.cpu_data;
                    idx_next   = 8'd0;
                    state_next = HALT;
                end
            end
            HALT: begin
                // An odd halt cycle needs one extra dummy cycle before reads begin
                state_next = parity ? ALIGN : READ;
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                buffer_next = bus.mem_data;
                state_next  = WRITE;
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx + 8'd1;
                    state_next = READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from registered state only, so no input reaches an output
    always_comb begin
        bus.mem_address = 16'h0000;
        bus.mem_r       = 1'b0;
        bus.oam_w       = 1'b0;
        bus.oam_address = 8'h00;
        bus.oam_data    = 8'h00;
        bus.cpu_halt    = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        unique case (state)
            IDLE: begin
            end
            HALT, ALIGN: begin
                bus.cpu_halt = 1'b1;
                bus.busy     = 1'b1;
            end
            READ: begin
                bus.cpu_halt    = 1'b1;
                bus.busy        = 1'b1;
                bus.mem_r       = 1'b1;
                bus.mem_address = {page, idx};
            end
            WRITE: begin
                bus.cpu_halt    = 1'b1;
                bus.busy        = 1'b1;
                bus.oam_w       = 1'b1;
                bus.oam_address = idx;
                bus.oam_data    = buffer;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized self-checking bench for oam_dma against a page-copy model
module tb_oam_dma;

    logic CLK;
    logic Reset;

    oam_dma_if bus ();

    oam_dma dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference cpu_memory contents and OAM as seen through the write port
    logic [7:0]  mem_m [0:65535];
    logic [7:0]  oam_m [0:255];

    int          n_checks = 0;
    int          n_fail   = 0;

    // Scoreboard state for the monitor
    logic [7:0]  exp_page = 8'h00;
    logic [7:0]  exp_idx  = 8'h00;
    logic [15:0] last_rd_addr = 16'h0000;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          edges  = 0;

    // $0000-$1FFF mirrors the 2 KiB internal RAM
    function automatic logic [15:0] mirror(input logic [15:0] a);
        return (a < 16'h2000) ? (a & 16'h07FF) : a;
    endfunction

    assign bus.mem_data = mem_m[mirror(bus.mem_address)];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count clock edges since reset release; the CPU cycle parity is edges % 2
    always @(posedge CLK or posedge Reset) begin
        if (Reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // OAM model: capture every write strobe seen at the clock edge
    always @(posedge CLK) begin
        if (!Reset && bus.oam_w) oam_m[bus.oam_address] <= bus.oam_data;
    end

    // Per-cycle monitor: read address sequence, write pairing, idle quietness
    always @(negedge CLK) begin
        if (!Reset) begin
            if (bus.mem_r) begin
                check("rd_addr", {16'h0, bus.mem_address}, {16'h0, exp_page, exp_idx});
                check("rd_wr_excl", {31'h0, bus.oam_w}, 32'h0);
                last_rd_addr = bus.mem_address;
                exp_idx = exp_idx + 8'd1;
                rd_cnt++;
            end
            if (bus.oam_w) begin
                logic [7:0] prev_idx;
                prev_idx = exp_idx - 8'd1;
                check("oam_addr", {24'h0, bus.oam_address}, {24'h0, prev_idx});
                check("oam_data", {24'h0, bus.oam_data}, {24'h0, mem_m[mirror(last_rd_addr)]});
                check("oam_w_halted", {31'h0, bus.cpu_halt}, 32'h1);
                wr_cnt++;
            end
            if (!bus.busy) begin
                check("idle_quiet", {28'h0, bus.cpu_halt, bus.mem_r, bus.oam_w, bus.done}, 32'h0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {27'h0, bus.cpu_halt, bus.busy, bus.done, bus.mem_r, bus.oam_w}, 32'h0);
        check({tag, "_data"}, {bus.mem_address, bus.oam_address, bus.oam_data}, 32'h0);
    endtask

    // Run one transfer of a page with a chosen halt-cycle parity and check it end to end
    task automatic run_dma(input logic [7:0] page, input bit odd, input int retrig_at, input bit trig_in_done);
        int halt_cnt;
        int done_cnt;
        int first_rd;
        bit finished;
        halt_cnt = 0;
        done_cnt = 0;
        first_rd = -1;
        finished = 1'b0;
        @(negedge CLK);
        // Parity in the HALT cycle is (edges+1)%2, so odd wants an even count now
        if (((edges % 2) == 0) != odd) @(negedge CLK);
        for (int i = 0; i < 256; i++) oam_m[i] = 8'hxx;
        exp_page = page;
        exp_idx  = 8'h00;
        rd_cnt   = 0;
        wr_cnt   = 0;
        bus.cpu_w       = 1'b1;
        bus.cpu_address = 16'h4014;
        bus.cpu_data    = page;
        @(negedge CLK);
        bus.cpu_w    = 1'b0;
        bus.cpu_data = ~page;
        for (int cyc = 0; cyc < 700; cyc++) begin
            bus.cpu_w = (cyc == retrig_at);
            if (bus.cpu_halt) halt_cnt++;
            if (bus.mem_r && first_rd < 0) first_rd = cyc;
            if (bus.done) begin
                done_cnt++;
                check("done_busy", {30'h0, bus.busy, bus.cpu_halt}, 32'h2);
                bus.cpu_w = trig_in_done;
                @(negedge CLK);
                bus.cpu_w = 1'b0;
                check("after_done", {30'h0, bus.busy, bus.done}, 32'h0);
                finished = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("finished", {31'h0, finished}, 32'h1);
        check("halt_cycles", halt_cnt, odd ? 32'd514 : 32'd513);
        check("first_read_cycle", first_rd, odd ? 32'd2 : 32'd1);
        check("done_pulses", done_cnt, 32'd1);
        check("read_count", rd_cnt, 32'd256);
        check("write_count", wr_cnt, 32'd256);
        check("last_read", {16'h0, last_rd_addr}, {16'h0, page, 8'hFF});
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, i[7:0]};
            check("oam_content", {24'h0, oam_m[i]}, {24'h0, mem_m[mirror(a)]});
        end
        repeat (3) @(negedge CLK);
        check("stays_idle", {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        logic [7:0] pg;
        int         snap;
        bit         found;
        Reset           = 1'b1;
        bus.cpu_w       = 1'b0;
        bus.cpu_address = 16'h0000;
        bus.cpu_data    = 8'h00;
        for (int a = 0; a < 65536; a++) mem_m[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem_m[16'h0200 + i] = 8'(i);

        @(negedge CLK);
        check_all_zero("reset");
        @(negedge CLK);
        Reset = 1'b0;

        // Write to a neighbouring register, then a read cycle of $4014
        bus.cpu_w       = 1'b1;
        bus.cpu_address = 16'h4015;
        bus.cpu_data    = 8'h02;
        @(negedge CLK);
        bus.cpu_w       = 1'b0;
        bus.cpu_address = 16'h4014;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_all_zero("no_trigger");
        end

        run_dma(8'h02, 1'b0, -1, 1'b0);
        run_dma(8'h02, 1'b1, -1, 1'b0);
        run_dma(8'h07, 1'($urandom), -1, 1'b0);
        run_dma(8'h04, 1'($urandom), 100, 1'b1);

        // Abandon a transfer with an asynchronous reset between edges
        @(negedge CLK);
        exp_page        = 8'h05;
        exp_idx         = 8'h00;
        bus.cpu_w       = 1'b1;
        bus.cpu_address = 16'h4014;
        bus.cpu_data    = 8'h05;
        @(negedge CLK);
        bus.cpu_w = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (bus.oam_w && bus.oam_address == 8'h40) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("reach_idx_40", {31'h0, found}, 32'h1);
        #2 Reset = 1'b1;
        #1 check_all_zero("async_reset");
        snap = wr_cnt;
        @(negedge CLK);
        Reset = 1'b0;
        repeat (20) @(negedge CLK);
        check("no_writes_after_reset", wr_cnt, snap);
        check("idle_after_reset", {31'h0, bus.busy}, 32'h0);

        run_dma(8'h03, 1'($urandom), -1, 1'b0);
        run_dma(8'h00, 1'($urandom), -1, 1'b0);
        run_dma(8'hFF, 1'($urandom), -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom);
            run_dma(pg, 1'($urandom), int'($urandom_range(0, 500)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus-master engine that implements the NES sprite DMA register at $4014.
- A CPU write of page P to $4014 halts the CPU. The engine then reads the 256 bytes P00-PFF from cpu_memory through a dedicated read port and writes each byte into PPU OAM.
- It is the initiator on the cpu_memory read interface, where cpu_memory is the responder. It sits between the cpu6502 core, cpu_memory and the PPU OAM.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- XFER_LEN, 256, bytes per transfer. Must be a power of two and at most 256.

Ports:
- CLK  input  1  system clock. All state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- cpu_w  input  1  CPU write strobe for the current cycle.
- cpu_address  input  16  CPU bus address.
- cpu_data  input  8  CPU write data.
- mem_address  output  16  read address to cpu_memory DMA port.
- mem_r  output  1  read strobe to cpu_memory.
- mem_data  input  8  cpu_memory read data, valid within the same cycle it is addressed.
- oam_w  output  1  OAM write strobe.
- oam_address  output  8  OAM byte index.
- oam_data  output  8  OAM write data.
- cpu_halt  output  1  high while the DMA owns the bus. The CPU must not advance.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse after the final OAM write.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, idx=0, page=0, buffer=0, parity=0.
  - Every output is 0. Any in-progress transfer is abandoned with no further OAM writes.
- Parity flop: toggles on every posedge while not in reset. It marks even/odd CPU cycles; 0 = even.
- Trigger: in IDLE, if cpu_w=1 and cpu_address==DMA_REG_ADDR at a posedge:
  - page<=cpu_data, idx<=0, state<=HALT.
  - Writes to any other address are ignored.
  - Triggers are ignored in every non-IDLE state.
- States and transitions:
  - IDLE: outputs 0. Moves to HALT on trigger.
  - HALT: one dummy cycle. Goes to ALIGN if parity==1 in this cycle, else to READ.
  - ALIGN: one extra dummy cycle, then READ.
  - READ: mem_address={page,idx}, mem_r=1. At the posedge, buffer<=mem_data and state<=WRITE.
  - WRITE: oam_w=1, oam_address=idx, oam_data=buffer. At the posedge:
    - if idx==XFER_LEN-1: state<=DONE;
    - else idx<=idx+1, state<=READ.
  - DONE: done=1 for exactly one cycle, cpu_halt=0, then IDLE. A trigger in the DONE cycle is ignored.
- Output decode: all outputs are decoded from registered state only, with no input-to-output combinational paths.
  - cpu_halt=1 and busy=1 in HALT, ALIGN, READ and WRITE.
  - busy=1 in DONE.
  - mem_address, mem_r and the oam_* outputs are 0 outside their own state.
- Timing: with the trigger at posedge 0, cpu_halt rises in cycle 1.
  - Halted cycles = 1 + (1 if odd) + 2*XFER_LEN, i.e. 513 or 514 for 256 bytes.
  - done is asserted in the cycle after the last WRITE.
- Addressing:
  - {page,idx} is issued verbatim. The $0000-$1FFF mirroring is performed by cpu_memory, not here.
  - idx is 8 bits and never wraps mid-transfer; page FF reads FF00-FFFF.
- Conflict: the DMA read port is separate from the CPU port, so cpu_w/r activity from a misbehaving CPU during halt does not affect the transfer.

Test Plan:
- Even start: preload cpu_memory $0200-$02FF with value=index; write 8'h02 to $4014 with parity=0 -> cpu_halt high for exactly 513 cycles; OAM[i]==i for i=0..255; single done pulse; busy falls one cycle after done.
- Odd start: the same write with parity=1 at HALT -> exactly 514 halted cycles; ALIGN visited once; OAM contents identical to the even case.
- Per-cycle check, page 8'h07: first READ drives mem_address 16'h0700 with mem_r=1. The next cycle has oam_w=1, oam_address=0, oam_data=mem[$0700]. The last READ drives 16'h07FF. No oam_w is seen outside WRITE.
- Non-trigger and retrigger:
  - A write of 8'h02 to $4015 and a read of $4014 -> state stays IDLE and all outputs stay 0.
  - A second $4014 write during busy -> ignored; page is unchanged and the transfer length is still 513/514.
- Reset mid-transfer: assert Reset asynchronously (between edges) at idx=8'h40 during WRITE -> all outputs 0 immediately; no further oam_w. A fresh $4014 write of 8'h03 then completes normally, with OAM filled from $0300-$03FF.
- Zero-page mirror source: write 8'h00 with cpu_memory $0800-$08FF aliasing to $0000-$00FF -> mem_address 16'h0000-16'h00FF; OAM matches RAM $0000-$00FF.
